// File: rtl/ins_align_buffer_pkg.sv
// Shared types for the instruction alignment buffer: a parcel is one 16-bit
// instruction halfword tagged with the address it was fetched from.
package align_pkg;

    localparam int PARCEL_W   = 16;
    // Widest instruction address a parcel can carry; ADDR_W must not exceed it.
    localparam int ADDR_MAX_W = 32;

    typedef struct packed {
        logic [PARCEL_W-1:0]   data;
        logic [ADDR_MAX_W-1:0] addr;
    } parcel_t;

    // A parcel starts a 16-bit instruction unless its two low bits are 2'b11.
    function automatic logic is_compressed(input parcel_t p);
        return (p.data[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/ins_align_buffer_parcel_fifo.sv
// Circular parcel store: accepts 1..PPF parcels per push and releases 1 or 2
// parcels per pop, exposing the two oldest parcels for instruction assembly.
module parcel_fifo
    import align_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PPF   = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1,
    parameter int PN_W  = $clog2(PPF) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push_en,
    input  logic [PN_W-1:0]       push_n,
    input  parcel_t [PPF-1:0]     push_parcels,
    input  logic                  pop_en,
    input  logic                  pop_two,
    output logic [CNT_W-1:0]      count,
    output parcel_t               head0,
    output logic [PARCEL_W-1:0]   head1_data
);

    localparam int PTR_W = $clog2(DEPTH);

    parcel_t            mem_q [DEPTH];
    parcel_t            mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   pop_n_s;
    logic [CNT_W-1:0]   add_s;
    logic [CNT_W-1:0]   sub_s;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_n_s  = pop_two ? CNT_W'(2) : CNT_W'(1);
        add_s    = push_en ? CNT_W'(push_n) : CNT_W'(0);
        sub_s    = pop_en ? pop_n_s : CNT_W'(0);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                for (int k = 0; k < PPF; k++) begin
                    if (PN_W'(k) < push_n) begin
                        mem_d[wr_ptr_q + PTR_W'(k)] = push_parcels[k];
                    end else begin
                        mem_d[wr_ptr_q + PTR_W'(k)] = mem_q[wr_ptr_q + PTR_W'(k)];
                    end
                end
                wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(pop_n_s);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + add_s - sub_s;
        end
    end

    // State registers; reset empties the buffer and zeroes storage so the
    // head outputs are never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head0      = mem_q[rd_ptr_q];
    assign head1_data = mem_q[rd_ptr_q + PTR_W'(1)].data;

endmodule

// File: rtl/ins_align_buffer.sv
// Instruction alignment buffer: splits fetch words into parcels, drops the
// parcels before the fetch address, and presents one 16- or 32-bit
// instruction at a time to decode.
module ins_align_buffer
    import align_pkg::*;
#(
    parameter int FETCH_W = 32,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        f_valid,
    output logic                        f_ready,
    input  logic [FETCH_W-1:0]          f_data,
    input  logic [ADDR_W-1:0]           f_addr,
    input  logic                        flush,
    output logic                        d_valid,
    input  logic                        d_ready,
    output logic [31:0]                 d_ins,
    output logic                        d_comp,
    output logic [ADDR_W-1:0]           d_addr,
    output logic                        d_illegal,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PPF   = FETCH_W / PARCEL_W;
    localparam int OFF_W = $clog2(PPF);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PN_W  = $clog2(PPF) + 1;

    logic [OFF_W-1:0]    off_s;
    logic [ADDR_W-1:0]   base_s;
    logic [FETCH_W-1:0]  shifted_s;
    parcel_t [PPF-1:0]   push_parcels_s;
    logic [PN_W-1:0]     push_n_s;
    logic                push_en_s;
    logic                pop_en_s;
    parcel_t             h0_s;
    logic [PARCEL_W-1:0] h1_data_s;
    logic                h0_comp_s;
    logic                avail_s;

    // Fetch side: align the word so the parcel at f_addr lands in slot 0 and
    // tag each kept parcel with its own halfword address.
    always_comb begin
        off_s     = f_addr[OFF_W:1];
        base_s    = f_addr & ~ADDR_W'(1);
        shifted_s = f_data >> {off_s, 4'b0000};
        push_n_s  = PN_W'(PPF) - PN_W'(off_s);
        for (int k = 0; k < PPF; k++) begin
            push_parcels_s[k].data = shifted_s[k*PARCEL_W +: PARCEL_W];
            push_parcels_s[k].addr = ADDR_MAX_W'(base_s + ADDR_W'(2 * k));
        end
        f_ready   = (count <= CNT_W'(DEPTH - PPF));
        push_en_s = f_valid && f_ready && !flush;
    end

    // Decode side: an instruction issues only when all of its parcels are
    // already stored; a flush cycle never issues.
    always_comb begin
        h0_comp_s = is_compressed(h0_s);
        if (h0_comp_s) begin
            avail_s = (count >= CNT_W'(1));
            d_ins   = {16'h0000, h0_s.data};
        end else begin
            avail_s = (count >= CNT_W'(2));
            d_ins   = {h1_data_s, h0_s.data};
        end
        d_valid   = avail_s && !flush;
        pop_en_s  = d_valid && d_ready;
        d_comp    = h0_comp_s && (count != CNT_W'(0));
        d_addr    = h0_s.addr[ADDR_W-1:0];
        d_illegal = (h0_s.data == 16'h0000);
    end

    parcel_fifo #(
        .DEPTH (DEPTH),
        .PPF   (PPF),
        .CNT_W (CNT_W),
        .PN_W  (PN_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (flush),
        .push_en      (push_en_s),
        .push_n       (push_n_s),
        .push_parcels (push_parcels_s),
        .pop_en       (pop_en_s),
        .pop_two      (!h0_comp_s),
        .count        (count),
        .head0        (h0_s),
        .head1_data   (h1_data_s)
    );

endmodule

// File: doc/ins_align_buffer.md
INS_ALIGN_BUFFER -- requirements
Module: ins_align_buffer

Interface
REQ-001 Parameter FETCH_W, default 32, fetch word width in bits; legal values 32 and 64; PPF = FETCH_W/16 parcels per fetch.
REQ-002 Parameter DEPTH, default 8, parcel storage entries; power of two, at least 2*PPF.
REQ-003 Parameter ADDR_W, default 32, instruction address width.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 Rst  in  1  reset, asynchronous, active-low.
REQ-006 f_valid  in  1  fetch word present.
REQ-007 f_ready  out  1  buffer can accept one full fetch word.
REQ-008 f_data  in  FETCH_W  fetch word; parcel k = f_data[16k+15:16k].
REQ-009 f_addr  in  ADDR_W  halfword address of parcel 0 region; f_addr[0] ignored.
REQ-010 flush  in  1  discard all buffered parcels (branch taken or trap).
REQ-011 d_valid  out  1  complete instruction at head.
REQ-012 d_ready  in  1  decode accepts; low on hazard, mem_hold or dbg.
REQ-013 d_ins  out  32  instruction; compressed form zero-extended in [31:16].
REQ-014 d_comp  out  1  head instruction is 16-bit (drives comp_sig).
REQ-015 d_addr  out  ADDR_W  address of head instruction (drives IF_ID_pres_addr).
REQ-016 d_illegal  out  1  head parcel is 16'h0000.
REQ-017 count  out  $clog2(DEPTH)+1  parcels held.

Function
REQ-018 Each stored parcel carries its 16-bit data and its ADDR_W address.
REQ-019 Offset off = f_addr[$clog2(PPF):1]; parcels below off are dropped; accepted push stores PPF-off parcels in ascending order.
REQ-020 f_ready = (DEPTH - count) >= PPF, driven from registered count only, never from d_ready or f_valid.
REQ-021 Push occurs when f_valid && f_ready && !flush.
REQ-022 Head parcel h0 is compressed when h0[1:0] != 2'b11, else 32-bit.
REQ-023 Compressed: d_valid = count>=1; d_ins = {16'h0, h0}; d_comp = 1.
REQ-024 32-bit: d_valid = count>=2; d_ins = {h1, h0}; d_comp = 0; no issue while upper parcel is absent, including when it belongs to the next fetch.
REQ-025 d_ins, d_comp, d_addr, d_illegal are combinational from head entries; d_addr = address of h0.
REQ-026 Pop occurs when d_valid && d_ready && !flush; removes 1 parcel (compressed) or 2 (32-bit).
REQ-027 Latency: a parcel pushed at edge N is visible at head from cycle N+1; no bypass from f_data.
REQ-028 Simultaneous push and pop in one cycle: count_next = count + pushed - popped.
REQ-029 Read/write pointers wrap modulo DEPTH; a 32-bit instruction straddling the wrap is assembled correctly.
REQ-030 flush: d_valid forced low that cycle; at the edge, pointers and count clear to 0; same-cycle push and pop discarded.
REQ-031 count never exceeds DEPTH and never underflows; push when full or pop when empty is impossible by construction.
REQ-032 Outputs are don't-care-free: when d_valid=0, d_ins, d_comp, d_addr still reflect head storage without X.

Reset
REQ-033 Rst low asynchronously clears pointers and count to 0 and storage to 0, including mid-operation.
REQ-034 Reset values: f_ready=1, d_valid=0, d_ins=0, d_comp=0 (h0=0 gives compressed encoding, masked by d_valid=0), d_addr=0, d_illegal=1 masked by d_valid=0, count=0.

Structure
REQ-035 Package align_pkg holds PARCEL_W=16, parcel struct {data, addr}, and function is_compressed(parcel).
REQ-036 One sub-module, parcel_fifo: storage, pointers, count, multi-parcel push of 1..PPF and pop of 1..2; top handles offset, extraction and handshake.

Verification
REQ-037 Reset, then push 0x00130413 (addi) at addr 0x100 with FETCH_W=32 -> next cycle d_valid=1, d_comp=0, d_ins=0x00130413, d_addr=0x100.
REQ-038 Push 0x45014501 at 0x200 -> two issues: d_ins=0x00004501, d_comp=1, d_addr 0x200, then 0x202.
REQ-039 Push word with parcel1=0x0413, parcel0=0x4501 at 0x300, then stall fetch -> issue 0x4501, then d_valid=0 until next word supplies upper half 0x0013 -> d_ins=0x00130413, d_addr=0x302.
REQ-040 DEPTH=8, d_ready=0, push until count=8 -> f_ready=0 at count 7 and 8; then d_ready=1 with wrap-around straddling 32-bit instruction -> correct assembly.
REQ-041 f_addr=0x402 (off=1) -> only parcel 1 stored, count=1, d_addr=0x402; flush with simultaneous f_valid -> count=0 next cycle, push dropped.
REQ-042 Assert Rst low mid-stream with count=5 -> immediately count=0, d_valid=0, f_ready=1.
